// File: rtl/piksel_yanitlayici.sv
// Pixel responder: requests one pixel at a time, binarises it against a
// threshold and hands the result back with a held valid/acknowledge handshake.
module piksel_yanitlayici #(
  parameter int unsigned DEGER = 76800,
  parameter int unsigned GEC   = 3,
  parameter int unsigned ESIK  = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  veri_i,
  input  logic        veri_alindi_i,
  output logic        veri_al_o,
  output logic [7:0]  veri_o,
  output logic        veri_gonder_o,
  output logic        islem_bitti_o,
  output logic [16:0] indis_o
);

  localparam int unsigned IW = 17;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;

  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    ISTE   = 3'd1,
    BEKLE  = 3'd2,
    ISLE   = 3'd3,
    GONDER = 3'd4,
    BITTI  = 3'd5
  } durum_t;

  durum_t        durum_q, durum_d;
  logic [CW-1:0] sayac_q, sayac_d;
  logic [PW-1:0] piksel_q, piksel_d;
  logic          veri_al_d;
  logic [PW-1:0] veri_d;
  logic          gonder_d;
  logic          bitti_d;
  logic [IW-1:0] indis_d;

  // State and every output are registered together; reset clears them at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q       <= BOSTA;
      sayac_q       <= '0;
      piksel_q      <= '0;
      veri_al_o     <= 1'b0;
      veri_o        <= '0;
      veri_gonder_o <= 1'b0;
      islem_bitti_o <= 1'b0;
      indis_o       <= '0;
    end else begin
      durum_q       <= durum_d;
      sayac_q       <= sayac_d;
      piksel_q      <= piksel_d;
      veri_al_o     <= veri_al_d;
      veri_o        <= veri_d;
      veri_gonder_o <= gonder_d;
      islem_bitti_o <= bitti_d;
      indis_o       <= indis_d;
    end
  end

  // Next-state and next-output decode; a dropped enable outranks everything.
  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    piksel_d  = piksel_q;
    veri_al_d = 1'b0;
    veri_d    = veri_o;
    gonder_d  = veri_gonder_o;
    bitti_d   = islem_bitti_o;
    indis_d   = indis_o;

    if (durum_q != BOSTA && !en_i) begin
      durum_d  = BOSTA;
      sayac_d  = '0;
      piksel_d = '0;
      veri_d   = '0;
      gonder_d = 1'b0;
      bitti_d  = 1'b0;
      indis_d  = '0;
    end else begin
      unique case (durum_q)
        BOSTA: begin
          sayac_d  = '0;
          veri_d   = '0;
          gonder_d = 1'b0;
          bitti_d  = 1'b0;
          indis_d  = '0;
          if (en_i) begin
            durum_d   = ISTE;
            veri_al_d = 1'b1;
          end
        end
        ISTE: begin
          sayac_d = '0;
          durum_d = BEKLE;
        end
        BEKLE: begin
          sayac_d = sayac_q + CW'(1);
          if (sayac_q == CW'(GEC - 1)) begin
            piksel_d = veri_i;
            durum_d  = ISLE;
          end
        end
        ISLE: begin
          veri_d   = (piksel_q >= PW'(ESIK)) ? 8'hFF : 8'h00;
          gonder_d = 1'b1;
          durum_d  = GONDER;
        end
        GONDER: begin
          if (veri_alindi_i) begin
            gonder_d = 1'b0;
            veri_d   = '0;
            indis_d  = indis_o + IW'(1);
            if (indis_o + IW'(1) == IW'(DEGER)) begin
              bitti_d = 1'b1;
              durum_d = BITTI;
            end else begin
              veri_al_d = 1'b1;
              durum_d   = ISTE;
            end
          end
        end
        BITTI: begin
          bitti_d  = 1'b1;
          gonder_d = 1'b0;
        end
        default: durum_d = BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_piksel_yanitlayici.sv
// Bench for piksel_yanitlayici: a small frame instance for handshake/abort/reset
// scenarios and a larger ramp instance for whole-frame binarisation.
module tb_piksel_yanitlayici;

  localparam int unsigned DEG_A = 4;
  localparam int unsigned GEC_A = 3;
  localparam int unsigned DEG_B = 600;
  localparam int unsigned GEC_B = 1;
  localparam int unsigned ESIK  = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_a, ack_a, al_a, gonder_a, bitti_a;
  logic [7:0]  din_a, veri_a;
  logic [16:0] indis_a;
  logic        en_b, ack_b, al_b, gonder_b, bitti_b;
  logic [7:0]  din_b, veri_b;
  logic [16:0] indis_b;

  piksel_yanitlayici #(.DEGER(DEG_A), .GEC(GEC_A), .ESIK(ESIK)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .en_i(en_a), .veri_i(din_a),
    .veri_alindi_i(ack_a), .veri_al_o(al_a), .veri_o(veri_a),
    .veri_gonder_o(gonder_a), .islem_bitti_o(bitti_a), .indis_o(indis_a));

  piksel_yanitlayici #(.DEGER(DEG_B), .GEC(GEC_B), .ESIK(ESIK)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .en_i(en_b), .veri_i(din_b),
    .veri_alindi_i(ack_b), .veri_al_o(al_b), .veri_o(veri_b),
    .veri_gonder_o(gonder_b), .islem_bitti_o(bitti_b), .indis_o(indis_b));

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int last_req_a = 0;

  function automatic logic [7:0] binarise(input logic [7:0] p);
    return (p >= 8'(ESIK)) ? 8'hFF : 8'h00;
  endfunction

  // Value that binarises opposite to p, so a mistimed capture shows up.
  function automatic logic [7:0] garbage(input logic [7:0] p);
    return (p >= 8'(ESIK)) ? 8'h00 : 8'hFF;
  endfunction

  // One pixel on instance A: answer the request, then acknowledge after dly.
  task automatic pix_a(input logic [7:0] p, input int dly, input bit hold,
                       input bit spur, input int exp_period);
    bit ok;
    int t;
    logic [7:0] got, e;
    logic [16:0] idx0;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      if (al_a) begin ok = 1'b1; t = cyc; break; end
      @(negedge clk);
    end
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL req_timeout_a veri_al_o got 0 want 1");
      return;
    end
    vectors++;
    if (gonder_a !== 1'b0) begin
      miscompares++;
      $display("FAIL al_with_gonder got veri_gonder_o=%0b want 0", gonder_a);
    end
    if (exp_period > 0) begin
      vectors++;
      if (t - last_req_a !== exp_period) begin
        miscompares++;
        $display("FAIL pixel_period got %0d want %0d", t - last_req_a, exp_period);
      end
    end
    last_req_a = t;
    idx0  = indis_a;
    din_a = garbage(p);
    if (!hold) ack_a = spur;
    repeat (GEC_A) @(negedge clk);
    din_a = p;
    exp_q.push_back(binarise(p));
    @(negedge clk);
    din_a = garbage(p);
    vectors++;
    if ({al_a, gonder_a} !== 2'b00) begin
      miscompares++;
      $display("FAIL isle_outputs got al/gonder=%b want 00", {al_a, gonder_a});
    end
    @(negedge clk);
    if (!hold) ack_a = (dly == 0);
    vectors++;
    if ({al_a, gonder_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL gonder_entry got al/gonder=%b want 01", {al_a, gonder_a});
    end
    got = veri_a;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      vectors++;
      if ({al_a, gonder_a} !== 2'b01 || veri_a !== got || indis_a !== idx0) begin
        miscompares++;
        $display("FAIL hold_wait%0d got al/gonder=%b veri=%0h indis=%0d want 01 %0h %0d",
                 i, {al_a, gonder_a}, veri_a, indis_a, got, idx0);
      end
    end
    if (!hold) ack_a = 1'b1;
    e = exp_q.pop_front();
    vectors++;
    if (veri_a !== e) begin
      miscompares++;
      $display("FAIL veri_o got %0h want %0h (pixel %0h)", veri_a, e, p);
    end
    @(negedge clk);
    if (!hold) ack_a = 1'b0;
    vectors++;
    if (gonder_a !== 1'b0 || indis_a !== idx0 + 17'd1) begin
      miscompares++;
      $display("FAIL after_ack got gonder=%0b indis=%0d want 0 %0d",
               gonder_a, indis_a, idx0 + 17'd1);
    end
  endtask

  task automatic check_done_a(input string name);
    vectors++;
    if ({bitti_a, al_a, gonder_a} !== 3'b100 || indis_a !== 17'(DEG_A)) begin
      miscompares++;
      $display("FAIL %s got bitti/al/gonder=%b indis=%0d want 100 %0d",
               name, {bitti_a, al_a, gonder_a}, indis_a, DEG_A);
    end
  endtask

  task automatic check_idle_a(input string name);
    vectors++;
    if ({al_a, gonder_a, bitti_a} !== 3'b000 || veri_a !== 8'h00 || indis_a !== 17'd0) begin
      miscompares++;
      $display("FAIL %s got al/gonder/bitti=%b veri=%0h indis=%0d want 000 0 0",
               name, {al_a, gonder_a, bitti_a}, veri_a, indis_a);
    end
  endtask

  task automatic clear_a();
    en_a = 1'b0; ack_a = 1'b0;
    @(negedge clk);
    check_idle_a("clear_a");
    exp_q.delete();
  endtask

  // Drive instance A to the GONDER state of the current request without acking.
  task automatic to_gonder_a(input logic [7:0] p);
    for (int i = 0; i < 40 && !al_a; i++) @(negedge clk);
    repeat (GEC_A) @(negedge clk);
    din_a = p;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (gonder_a !== 1'b1) begin
      miscompares++;
      $display("FAIL to_gonder got gonder=%0b want 1", gonder_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 0; ack_a = 0; din_a = 0;
    en_b = 0; ack_b = 0; din_b = 0;
    #12;
    check_idle_a("reset_a");
    vectors++;
    if ({al_b, gonder_b, bitti_b} !== 3'b000 || veri_b !== 8'h00 || indis_b !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_b got al/gonder/bitti=%b veri=%0h indis=%0d want 000 0 0",
               {al_b, gonder_b, bitti_b}, veri_b, indis_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_a("idle_no_en");
  endtask

  task automatic test_frame();
    en_a = 1'b1;
    @(negedge clk);
    pix_a(8'h10, 0, 0, 0, 0);
    pix_a(8'h80, 0, 0, 0, GEC_A + 3);
    pix_a(8'h7F, 0, 0, 0, GEC_A + 3);
    pix_a(8'hFF, 0, 0, 0, GEC_A + 3);
    check_done_a("frame_done");
    repeat (5) begin
      @(negedge clk);
      check_done_a("bitti_sticky");
    end
    clear_a();
  endtask

  task automatic test_delayed_ack();
    en_a = 1'b1;
    @(negedge clk);
    pix_a(8'h20, 0, 0, 0, 0);
    pix_a(8'h90, 10, 0, 1, GEC_A + 3);
    pix_a(8'h40, 0, 0, 0, GEC_A + 3 + 10);
    pix_a(8'hC0, 0, 0, 0, GEC_A + 3);
    check_done_a("delayed_done");
    clear_a();
  endtask

  task automatic test_back_to_back();
    ack_a = 1'b1;
    en_a  = 1'b1;
    @(negedge clk);
    pix_a(8'h05, 0, 1, 0, 0);
    pix_a(8'hA0, 0, 1, 0, GEC_A + 3);
    pix_a(8'h81, 0, 1, 0, GEC_A + 3);
    pix_a(8'h00, 0, 1, 0, GEC_A + 3);
    check_done_a("b2b_done");
    clear_a();
  endtask

  task automatic test_abort();
    en_a = 1'b1;
    @(negedge clk);
    pix_a(8'h01, 0, 0, 0, 0);
    pix_a(8'hF0, 0, 0, 0, GEC_A + 3);
    for (int i = 0; i < 40 && !al_a; i++) @(negedge clk);
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check_idle_a("abort_bekle");
    en_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (al_a !== 1'b1 || indis_a !== 17'd0) begin
      miscompares++;
      $display("FAIL restart got al=%0b indis=%0d want 1 0", al_a, indis_a);
    end
    pix_a(8'h33, 0, 0, 0, 0);
    pix_a(8'hCC, 0, 0, 0, GEC_A + 3);
    pix_a(8'h80, 0, 0, 0, GEC_A + 3);
    pix_a(8'h7E, 0, 0, 0, GEC_A + 3);
    check_done_a("restart_done");
    clear_a();
    en_a = 1'b1;
    @(negedge clk);
    pix_a(8'h99, 0, 0, 0, 0);
    to_gonder_a(8'hEE);
    ack_a = 1'b1;
    en_a  = 1'b0;
    @(negedge clk);
    ack_a = 1'b0;
    check_idle_a("abort_with_ack");
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    en_a = 1'b1;
    @(negedge clk);
    pix_a(8'hB0, 0, 0, 0, 0);
    to_gonder_a(8'hF5);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gonder_a !== 1'b0 || veri_a !== 8'h00 || indis_a !== 17'd0) begin
      miscompares++;
      $display("FAIL async_rst got gonder=%0b veri=%0h indis=%0d want 0 0 0",
               gonder_a, veri_a, indis_a);
    end
    @(negedge clk);
    check_idle_a("rst_held");
    en_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_a("rst_release_no_en");
    en_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (al_a !== 1'b1 || indis_a !== 17'd0) begin
      miscompares++;
      $display("FAIL start_after_rst got al=%0b indis=%0d want 1 0", al_a, indis_a);
    end
    clear_a();
  endtask

  task automatic test_ramp();
    int acks, ff_seen, ff_exp;
    bit ok;
    logic [7:0] p, e;
    acks = 0; ff_seen = 0; ff_exp = 0;
    ack_b = 1'b1;
    en_b  = 1'b1;
    @(negedge clk);
    for (int k = 0; k < int'(DEG_B); k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (al_b) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL ramp_req_timeout at pixel %0d", k);
        break;
      end
      p = 8'(k % 256);
      if (p >= 8'(ESIK)) ff_exp++;
      din_b = garbage(p);
      repeat (GEC_B) @(negedge clk);
      din_b = p;
      exp_q.push_back(binarise(p));
      @(negedge clk);
      din_b = garbage(p);
      ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (gonder_b) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL ramp_gonder_timeout at pixel %0d", k);
        break;
      end
      e = exp_q.pop_front();
      acks++;
      if (veri_b == 8'hFF) ff_seen++;
      vectors++;
      if (veri_b !== e) begin
        miscompares++;
        $display("FAIL ramp_veri pixel %0d got %0h want %0h", k, veri_b, e);
      end
      @(negedge clk);
      vectors++;
      if (gonder_b !== 1'b0 || indis_b !== 17'(k + 1)) begin
        miscompares++;
        $display("FAIL ramp_indis pixel %0d got gonder=%0b indis=%0d want 0 %0d",
                 k, gonder_b, indis_b, k + 1);
      end
    end
    vectors++;
    if (acks !== int'(DEG_B) || ff_seen !== ff_exp) begin
      miscompares++;
      $display("FAIL ramp_counts got acks=%0d ff=%0d want %0d %0d",
               acks, ff_seen, DEG_B, ff_exp);
    end
    repeat (8) begin
      @(negedge clk);
      vectors++;
      if ({bitti_b, al_b, gonder_b} !== 3'b100 || indis_b !== 17'(DEG_B)) begin
        miscompares++;
        $display("FAIL ramp_sticky got bitti/al/gonder=%b indis=%0d want 100 %0d",
                 {bitti_b, al_b, gonder_b}, indis_b, DEG_B);
      end
    end
    en_b = 1'b0;
    ack_b = 1'b0;
    @(negedge clk);
    vectors++;
    if (bitti_b !== 1'b0 || indis_b !== 17'd0) begin
      miscompares++;
      $display("FAIL ramp_clear got bitti=%0b indis=%0d want 0 0", bitti_b, indis_b);
    end
  endtask

  // Global bound so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_frame();
    test_delayed_ack();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piksel_yanitlayici.md
PIKSEL_YANITLAYICI -- requirements
Module: piksel_yanitlayici

Interface
REQ-001 Parameter DEGER, default 76800, number of pixels per frame.
REQ-002 Parameter GEC, default 3, cycles from request pulse to veri_i sampling (range 1..15).
REQ-003 Parameter ESIK, default 128, 8-bit binarisation threshold.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 en_i  input  1  level enable; high starts or continues a frame, low aborts or clears it.
REQ-007 veri_i  input  8  pixel from initiator, valid GEC cycles after the veri_al_o pulse.
REQ-008 veri_alindi_i  input  1  initiator acknowledge of the presented output pixel.
REQ-009 veri_al_o  output  1  one-cycle request for the next input pixel.
REQ-010 veri_o  output  8  processed pixel.
REQ-011 veri_gonder_o  output  1  veri_o valid, held until acknowledged.
REQ-012 islem_bitti_o  output  1  frame complete, sticky.
REQ-013 indis_o  output  17  number of pixels acknowledged in the current frame.

Function
REQ-014 The FSM SHALL have the states BOSTA, ISTE, BEKLE, ISLE, GONDER and BITTI, one-hot or binary encoded.
REQ-015 BOSTA SHALL hold all outputs low and indis at 0, and SHALL move to ISTE on the first cycle with en_i=1.
REQ-016 ISTE SHALL drive veri_al_o=1 for exactly one cycle, clear the wait counter, and move to BEKLE.
REQ-017 BEKLE SHALL count cycles and, on the GEC-th cycle after the ISTE cycle, capture veri_i into an internal register and move to ISLE.
REQ-018 ISLE SHALL register veri_o = 8'hFF if the captured pixel >= ESIK, otherwise 8'h00, with an unsigned 8-bit compare, and SHALL move to GONDER.
REQ-019 GONDER SHALL hold veri_gonder_o=1 and veri_o stable until the first cycle with veri_alindi_i=1.
REQ-020 veri_alindi_i SHALL be ignored whenever veri_gonder_o=0, and early or spurious acknowledges SHALL NOT advance the FSM.
REQ-021 On an acknowledge, veri_gonder_o SHALL drop on the next cycle and indis SHALL increment.
REQ-022 After an acknowledge, the FSM SHALL go to BITTI if indis+1 == DEGER, otherwise to ISTE.
REQ-023 Minimum per-pixel period SHALL be GEC+3 cycles when the acknowledge is immediate.
REQ-024 In BITTI, islem_bitti_o SHALL be 1, veri_al_o and veri_gonder_o SHALL be 0, and indis_o SHALL hold DEGER.
REQ-025 In BITTI, en_i=0 SHALL return the FSM to BOSTA and clear islem_bitti_o and indis.
REQ-026 en_i=0 in any state other than BOSTA SHALL force BOSTA on the next edge, clear indis, drop all outputs, and discard any pending pixel.
REQ-027 veri_alindi_i and en_i=0 in the same cycle SHALL resolve as an abort; indis SHALL be cleared, not incremented.
REQ-028 indis SHALL be 17 bits, SHALL never exceed DEGER, and SHALL never wrap.
REQ-029 veri_al_o SHALL never be high while veri_gonder_o is high; only one pixel is in flight at a time.

Reset
REQ-030 rst_i=0 SHALL immediately, without waiting for a clock, force BOSTA and set veri_al_o=0, veri_gonder_o=0, islem_bitti_o=0, veri_o=8'h00, indis_o=0 and the wait counter to 0.
REQ-031 After rst_i deasserts, the block SHALL act only on the first rising edge with rst_i=1, and SHALL start a frame only if en_i=1 on that edge.
REQ-032 An asynchronous reset mid-frame SHALL abandon the frame; no partial result is retained.

Verification
REQ-033 Bench SHALL cover this scenario: DEGER=4, GEC=3, inputs 0x10, 0x80, 0x7F, 0xFF, immediate acknowledge -> outputs 00, FF, 00, FF, indis_o 1..4, islem_bitti_o=1 after the 4th acknowledge, pixel period 6 cycles.
REQ-034 Bench SHALL cover this scenario: acknowledge delayed 10 cycles on pixel 2 -> veri_gonder_o and veri_o held constant for 10 cycles, no veri_al_o pulse in that interval, indis_o unchanged until the acknowledge.
REQ-035 Bench SHALL cover this scenario: veri_alindi_i held high continuously -> each pixel acknowledged on its first GONDER cycle, no skipped or duplicated pixels, indis_o increments by exactly 1 per pixel.
REQ-036 Bench SHALL cover this scenario: en_i dropped in BEKLE after pixel 2 -> BOSTA next cycle, indis_o=0, outputs low; en_i reasserted -> new frame starts at indis 0 with a fresh veri_al_o pulse.
REQ-037 Bench SHALL cover this scenario: rst_i pulled low between clock edges during GONDER -> veri_gonder_o falls without a clock edge, and all outputs read 0 at the next edge.
REQ-038 Bench SHALL cover this scenario: full-size run with DEGER=76800 on a ramp pattern (pixel = index mod 256) -> exactly 76800 acknowledges, output FF exactly where pixel >= 128, islem_bitti_o sticky until en_i=0.
